bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-add-3 (double dabble). It sits directly downstream of the calculator arithmetic stage. It takes the binary result plus its sign flag and produces packed BCD digits for the 7-segment display driver. It replaces per-digit divide/modulo logic with a small multi-cycle datapath and a start/done handshake.

---
 rtl/bin2bcd_pkg.sv | 6 +
 rtl/bin2bcd_seq_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 96 +++++++++
 tb/tb_bin2bcd_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam int DIG_W = 4;
  localparam int ADD3_TH = 5;
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3_digit: double-dabble correction cell, adds 3 to a BCD digit of 5 or more
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d_in,
  output logic [DIG_W-1:0] d_out
);
  always_comb d_out = (d_in >= DIG_W'(ADD3_TH)) ? d_in + DIG_W'(3) : d_in;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle shift-add-3 binary to packed BCD converter with start/done handshake
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  input  logic                      neg_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIG_W*DIGITS-1:0]   bcd_out,
  output logic                      neg_out,
  output logic                      overflow
);
  localparam int unsigned MAXVAL = 10 ** DIGITS - 1;
  localparam int BCD_W = DIG_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
  logic neg_q, neg_d, ovf_q, ovf_d, neg_out_q, neg_out_d, ovf_out_q, ovf_out_d, done_q, done_d;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (.d_in(scr_q[DIG_W*g +: DIG_W]), .d_out(adj[DIG_W*g +: DIG_W]));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scr_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      neg_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scr_q     <= scr_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      neg_out_q <= neg_out_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end
  always_comb
    state_d = (state_q == IDLE)   ? (start ? SHIFT : IDLE) :
              (state_q == SHIFT)  ? ((cnt_q == CNT_W'(1)) ? FINISH : SHIFT) : IDLE;
  always_comb begin
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scr_d     = scr_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    neg_out_d = neg_out_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shreg_d = bin_in;
        scr_d   = '0;
        neg_d   = neg_in;
        ovf_d   = 32'(bin_in) > MAXVAL;
        cnt_d   = CNT_W'(BIN_W);
      end
      SHIFT: begin
        {scr_d, shreg_d} = {adj[BCD_W-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      FINISH: begin
        bcd_d     = ovf_q ? {DIGITS{DIG_W'(9)}} : scr_q;
        neg_out_d = neg_q;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    busy     = state_q != IDLE;
    done     = done_q;
    bcd_out  = bcd_q;
    neg_out  = neg_out_q;
    overflow = ovf_out_q;
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq against an arithmetic reference
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, neg_in = 1'b0;
  logic [13:0] bin_in = '0;
  logic busy, done, neg_out, overflow;
  logic [15:0] bcd_out;
  int checks = 0, failures = 0;

  bin2bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .neg_in(neg_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .neg_out(neg_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r = '0;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic conv(input int v, input logic n);
    int cyc;
    @(negedge clk);
    start = 1'b1; bin_in = 14'(v); neg_in = n;
    @(posedge clk); #1;
    start = 1'b0; bin_in = ~bin_in; neg_in = ~n;
    chk("busy_mid", busy, 1);
    wait_done(cyc);
    chk("latency", cyc, 15);
    chk("bcd", bcd_out, ref_bcd(v));
    chk("neg", neg_out, n);
    chk("ovf", overflow, v > 9999);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic count_dones(input int n, output int d);
    d = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) d++;
    end
  endtask

  initial begin
    int cyc, d, v;
    #1;
    chk("rst_bcd", bcd_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_neg", neg_out, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); rst = 1'b1;
    conv(9801, 0);
    conv(0, 1);
    conv(37, 0);
    conv(10000, 0);
    conv(16383, 1);
    conv(9999, 0);
    // start during busy must be ignored
    @(negedge clk); start = 1'b1; bin_in = 14'd1234; neg_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; bin_in = 14'd5678; neg_in = 1'b1;
    @(posedge clk); #1; start = 1'b0; bin_in = 14'd999;
    wait_done(cyc);
    chk("ign_latency", cyc, 10);
    chk("ign_bcd", bcd_out, 16'h1234);
    chk("ign_neg", neg_out, 0);
    count_dones(30, d);
    chk("ign_no_second", d, 0);
    // back-to-back with start held high
    @(negedge clk); start = 1'b1; bin_in = 14'd1; neg_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_done(cyc);
      chk("b2b_period", cyc, 16);
      chk("b2b_bcd", bcd_out, ref_bcd(i));
      bin_in = 14'(i + 1);
      if (i == 3) start = 1'b0;
    end
    // asynchronous reset mid-conversion
    @(negedge clk); start = 1'b1; bin_in = 14'd4321; neg_in = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    chk("arst_bcd", bcd_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_neg", neg_out, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk); rst = 1'b1;
    count_dones(25, d);
    chk("arst_no_done", d, 0);
    conv(42, 0);
    for (int i = 0; i < 30; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
      conv(v, 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
